demux_1_2_buf: RTL and testbench
================================

# demux_1_2_buf

Registered 1-to-2 word demultiplexer: accepts one WIDTH-bit word per cycle on a valid/ready input port and steers it, by a per-word select bit, into one of two single-entry output buffers (A for select 0, B for select 1), each with its own valid/ready handshake. It is the distribution counterpart of the datapath 2:1 multiplexers. It sits where a single producer, such as the ALU or load result, must feed one of two consumers, such as write-back or a forwarding/branch unit. Per-destination 16-bit transfer counters support debug and verification.

## Interface
- WIDTH, 32, data word width
- CNT_W, 16, width of each per-destination transfer counter
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  WIDTH  word to route
- in_sel  input  1  destination: 0 = A, 1 = B
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  block accepts the word this cycle
- a_data  output  WIDTH  buffered word for destination A
- a_valid  output  1  a_data holds an undelivered word
- a_ready  input  1  consumer A takes a_data this cycle
- b_data  output  WIDTH  buffered word for destination B
- b_valid  output  1  b_data holds an undelivered word
- b_ready  input  1  consumer B takes b_data this cycle
- a_count  output  CNT_W  words accepted for A since reset
- b_count  output  CNT_W  words accepted for B since reset

## Operation
- Each output slot holds a data register and a valid flag; slot A and slot B are independent.
- Transfer definitions:
  - input transfer = in_valid & in_ready;
  - A drain = a_valid & a_ready;
  - B drain = b_valid & b_ready.
- in_ready is combinational:
  - in_sel = 0: in_ready = ~a_valid | a_ready;
  - in_sel = 1: in_ready = ~b_valid | b_ready.
  - in_ready depends on in_sel even when in_valid = 0.
- Per-slot update on each clock. Slot X is A for in_sel = 0 and B for in_sel = 1.
  - Input transfer to X: X_data <= in_data, X_valid <= 1. This holds whether X was empty or draining in the same cycle.
  - Drain of X with no input transfer to X: X_valid <= 0, X_data holds.
  - Otherwise the slot holds.
- X_data is stable while X_valid = 1 and X_ready = 0. Data is never overwritten while undelivered.
- The unselected slot is unaffected by the input. It may drain in the same cycle the other slot loads.
- Counters:
  - a_count increments on each input transfer with in_sel = 0; b_count on each with in_sel = 1.
  - Counters wrap modulo 2^CNT_W (0xFFFF -> 0x0000).
  - At most one counter changes per cycle.
- No reordering within a destination. Words to one destination emerge in acceptance order.

## Timing
- Reset (asynchronous, active while rst = 1): a_valid = b_valid = 0, a_data = b_data = 0, a_count = b_count = 0.
  - in_ready reads 1 while in reset, since both slots are empty.
  - Inputs during reset are ignored and not counted.
- Reset mid-operation discards buffered words immediately, without waiting for a clock edge.
- Latency: a word accepted at edge N is visible on X_data with X_valid = 1 after edge N, i.e. one cycle.
- Throughput: one word per cycle sustained to a single destination if its consumer holds ready = 1. Alternating destinations also sustain one word per cycle.
- Backpressure: a full slot with X_ready = 0 deasserts in_ready for words selecting that slot only. Words to the other slot still flow.
- Combinational paths:
  - a_ready/b_ready -> in_ready;
  - in_sel -> in_ready.
  - All other outputs are registered.

## Test plan
- Reset: assert rst mid-stream with a_valid = 1 -> a_valid, b_valid, a_data, b_data and both counts read 0 before the next edge; in_ready = 1.
- Single steer: send 0xDEADBEEF sel 0, then 0x12345678 sel 1, consumers ready -> a_data = 0xDEADBEEF one cycle after acceptance; b_data = 0x12345678; a_count = 1, b_count = 1.
- Backpressure: a_ready = 0, send 0x1 then 0x2 to A -> 0x1 held on a_data, in_ready = 0 for sel 0. Raise a_ready -> 0x1 delivered, 0x2 loaded in the same edge, a_valid stays 1.
- Independence: A full and stalled; send 0xAA to B -> accepted, b_data = 0xAA next cycle; a_data unchanged.
- Streaming: 8 back-to-back words alternating sel with both ready = 1 -> in_ready constantly 1; order preserved per destination; a_count = b_count = 4.
- Wrap: preload via 65535 transfers to A then one more -> a_count = 0x0000; b_count unchanged.

Source files
------------

// File: rtl/demux_1_2_buf.sv
// demux_1_2_buf: steers one valid/ready word per cycle into one of two single-entry output buffers
module demux_1_2_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic load_a, load_b;

    // a slot can take a word when it is empty or being drained this cycle
    always_comb begin
        in_ready = in_sel ? (~b_valid | b_ready) : (~a_valid | a_ready);
        load_a   = in_valid & in_ready & ~in_sel;
        load_b   = in_valid & in_ready & in_sel;
    end

    // slot A: load wins over drain so a same-cycle drain and refill keeps a_valid high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data  <= '0;
            a_valid <= 1'b0;
        end else if (load_a) begin
            a_data  <= in_data;
            a_valid <= 1'b1;
        end else if (a_ready) begin
            a_valid <= 1'b0;
        end
    end

    // slot B: same policy as slot A
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_data  <= '0;
            b_valid <= 1'b0;
        end else if (load_b) begin
            b_data  <= in_data;
            b_valid <= 1'b1;
        end else if (b_ready) begin
            b_valid <= 1'b0;
        end
    end

    // per-destination accepted-word counters, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            a_count <= a_count + CNT_W'(load_a);
            b_count <= b_count + CNT_W'(load_b);
        end
    end

endmodule

// File: tb/tb_demux_1_2_buf.sv
// tb_demux_1_2_buf: directed-vector self-checking bench for demux_1_2_buf
module tb_demux_1_2_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_sel, in_valid, in_ready;
    logic [31:0] a_data, b_data;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [15:0] a_count, b_count;

    int n_cmp = 0;
    int n_bad = 0;

    demux_1_2_buf #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .a_count(a_count), .b_count(b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_data = '0; in_sel = 1'b0; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_count", a_count, 0);
        tick();
        tick();
        rst = 1'b0;

        a_ready = 1'b1; b_ready = 1'b1;
        drive(1, 0, 32'hDEADBEEF);
        chk("steer_rdy_a", in_ready, 1);
        tick();
        chk("steer_a_valid", a_valid, 1);
        chk("steer_a_data", a_data, 32'hDEADBEEF);
        drive(1, 1, 32'h12345678);
        chk("steer_rdy_b", in_ready, 1);
        tick();
        chk("steer_b_valid", b_valid, 1);
        chk("steer_b_data", b_data, 32'h12345678);
        chk("steer_a_drained", a_valid, 0);
        chk("steer_a_count", a_count, 1);
        chk("steer_b_count", b_count, 1);
        drive(0, 0, 0);
        tick();
        chk("steer_b_drained", b_valid, 0);

        a_ready = 1'b0; b_ready = 1'b0;
        drive(1, 0, 32'h1);
        tick();
        chk("bp_a_data1", a_data, 32'h1);
        drive(1, 0, 32'h2);
        chk("bp_in_ready0", in_ready, 0);
        tick();
        chk("bp_a_held", a_data, 32'h1);
        chk("bp_a_count", a_count, 2);
        chk("bp_still_blocked", in_ready, 0);

        drive(1, 1, 32'hAA);
        chk("ind_rdy_b", in_ready, 1);
        tick();
        chk("ind_b_valid", b_valid, 1);
        chk("ind_b_data", b_data, 32'hAA);
        chk("ind_a_unch", a_data, 32'h1);
        chk("ind_a_valid", a_valid, 1);
        chk("ind_b_count", b_count, 2);

        a_ready = 1'b1;
        drive(1, 0, 32'h2);
        chk("bp_release_rdy", in_ready, 1);
        tick();
        chk("bp_a_data2", a_data, 32'h2);
        chk("bp_a_valid_kept", a_valid, 1);
        chk("bp_a_count3", a_count, 3);
        drive(0, 0, 0);
        tick();
        chk("bp_a_drained", a_valid, 0);
        b_ready = 1'b1;
        tick();
        chk("ind_b_drained", b_valid, 0);

        for (int i = 0; i < 8; i++) begin
            drive(1, i[0], 32'h100 + i);
            chk("stream_rdy", in_ready, 1);
            tick();
            if (i[0]) begin
                chk("stream_b_data", b_data, 32'h100 + i);
                chk("stream_b_valid", b_valid, 1);
            end else begin
                chk("stream_a_data", a_data, 32'h100 + i);
                chk("stream_a_valid", a_valid, 1);
            end
        end
        chk("stream_a_count", a_count, 7);
        chk("stream_b_count", b_count, 6);

        drive(1, 0, 32'h5A5A);
        repeat (65528) tick();
        chk("wrap_pre_a", a_count, 16'hFFFF);
        tick();
        chk("wrap_a_zero", a_count, 0);
        chk("wrap_b_unch", b_count, 6);

        a_ready = 1'b0; b_ready = 1'b0;
        drive(1, 1, 32'hBB);
        tick();
        chk("mid_a_full", a_valid, 1);
        chk("mid_b_full", b_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_a_valid", a_valid, 0);
        chk("mid_rst_b_valid", b_valid, 0);
        chk("mid_rst_a_data", a_data, 0);
        chk("mid_rst_b_data", b_data, 0);
        chk("mid_rst_a_count", a_count, 0);
        chk("mid_rst_b_count", b_count, 0);
        chk("mid_rst_rdy_b", in_ready, 1);
        drive(1, 0, 32'hCC);
        chk("mid_rst_rdy_a", in_ready, 1);
        tick();
        chk("rst_ignore_a_cnt", a_count, 0);
        chk("rst_ignore_a_valid", a_valid, 0);
        drive(0, 0, 0);
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
